// File: rtl/lifo_arb.sv
// lifo_arb: round-robin arbiter/sequencer sharing one external LIFO between
// nR requesters. Each requester pushes or pops over a valid/ready handshake,
// at most one transaction is granted per cycle, and popped data returns on a
// registered response channel tagged with the requester index. A requester
// may hold exclusive access across a burst by asserting reqLock.
//
// Build option: define LIFO_ARB_STATS_EN to add the saturating statistics
// counters statPush, statPop and statStall (32 bits each).
module lifo_arb #(
    parameter int bW = 8,
    parameter int nR = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [nR-1:0]         reqValid,
    input  logic [nR-1:0]         reqOp,
    input  logic [nR-1:0]         reqLock,
    input  logic [nR*bW-1:0]      reqData,
    output logic [nR-1:0]         reqReady,
    output logic                  rspValid,
    output logic [bW-1:0]         rspData,
    output logic [$clog2(nR)-1:0] rspId,
    output logic                  lifoPush,
    output logic                  lifoPop,
    output logic [bW-1:0]         lifoPushData,
    input  logic                  lifoFull,
    input  logic                  lifoEmpty,
    input  logic [bW-1:0]         lifoPopData
`ifdef LIFO_ARB_STATS_EN
    ,
    output logic [31:0]           statPush,
    output logic [31:0]           statPop,
    output logic [31:0]           statStall
`endif
);

    localparam int IW = $clog2(nR);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_rr_ptr;
    logic            r_rsp_valid;
    logic [bW-1:0]   r_rsp_data;
    logic [IW-1:0]   r_rsp_id;

    logic [nR-1:0]   w_elig;
    logic            w_grant;
    logic [IW-1:0]   w_gidx;
    logic            w_glock;
    int              w_target;

    // Per-requester eligibility: valid, the LIFO can take the operation, and
    // (while locked) the requester owns the lock.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        w_elig = '0;
        for (int i = 0; i < nR; i++) begin
            w_elig[i] = reqValid[i] && (reqOp[i] ? !lifoEmpty : !lifoFull);
            if (r_state == ST_LOCKED && r_owner != IW'(i)) begin
                w_elig[i] = 1'b0;
            end
        end
    end

    // Cyclic search for the first eligible requester at or after the pointer.
    always_comb begin
        w_grant  = 1'b0;
        w_gidx   = '0;
        w_target = 0;
        for (int k = 0; k < nR; k++) begin
            w_target = int'(r_rr_ptr) + k;
            if (w_target >= nR) begin
                w_target = w_target - nR;
            end
            for (int i = 0; i < nR; i++) begin
                if (!w_grant && i == w_target && w_elig[i]) begin
                    w_grant = 1'b1;
                    w_gidx  = IW'(i);
                end
            end
        end
    end

    // Drive the handshake and the LIFO port for the winner; all quiet in reset.
    always_comb begin
        reqReady     = '0;
        lifoPush     = 1'b0;
        lifoPop      = 1'b0;
        lifoPushData = '0;
        w_glock      = 1'b0;
        if (rst && w_grant) begin
            for (int i = 0; i < nR; i++) begin
                if (w_gidx == IW'(i)) begin
                    reqReady[i]  = 1'b1;
                    lifoPush     = !reqOp[i];
                    lifoPop      = reqOp[i];
                    lifoPushData = reqOp[i] ? '0 : reqData[i*bW +: bW];
                    w_glock      = reqLock[i];
                end
            end
        end
    end

    // Lock FSM, round-robin pointer and registered pop response.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // in this block sees the pre-edge values of the others.
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else begin
            r_rsp_valid <= lifoPop;
            if (lifoPop) begin
                r_rsp_data <= lifoPopData;
                r_rsp_id   <= w_gidx;
            end
            if (w_grant) begin
                r_rr_ptr <= (w_gidx == IW'(nR - 1)) ? '0 : w_gidx + 1'b1;
                case (r_state)
                    ST_IDLE: begin
                        if (w_glock) begin
                            r_state <= ST_LOCKED;
                            r_owner <= w_gidx;
                        end
                    end
                    ST_LOCKED: begin
                        // Only the owner can win here, so its reqLock decides.
                        if (!w_glock) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign rspValid = r_rsp_valid;
    assign rspData  = r_rsp_data;
    assign rspId    = r_rsp_id;

`ifdef LIFO_ARB_STATS_EN
    logic [31:0] r_stat_push;
    logic [31:0] r_stat_pop;
    logic [31:0] r_stat_stall;

    // Saturating activity counters: granted pushes, granted pops, stalled cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stat_push  <= '0;
            r_stat_pop   <= '0;
            r_stat_stall <= '0;
        end else begin
            if (lifoPush && r_stat_push != 32'hFFFF_FFFF) begin
                r_stat_push <= r_stat_push + 32'd1;
            end
            if (lifoPop && r_stat_pop != 32'hFFFF_FFFF) begin
                r_stat_pop <= r_stat_pop + 32'd1;
            end
            if ((|reqValid) && !w_grant && r_stat_stall != 32'hFFFF_FFFF) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign statPush  = r_stat_push;
    assign statPop   = r_stat_pop;
    assign statStall = r_stat_stall;
`endif

endmodule

// File: tb/tb_lifo_arb.sv
// tb_lifo_arb: self-checking bench for lifo_arb (nR=2, bW=8) attached to a
// behavioural 4-entry LIFO. Directed vector table, hand-written lock/reset/
// empty sequences, then randomized traffic against a reference model.
module tb_lifo_arb;

    localparam int BW = 8;
    localparam int NR = 2;
    localparam int EC = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NR-1:0]   reqValid = '0;
    logic [NR-1:0]   reqOp = '0;
    logic [NR-1:0]   reqLock = '0;
    logic [NR*BW-1:0] reqData = '0;
    logic [NR-1:0]   reqReady;
    logic            rspValid;
    logic [BW-1:0]   rspData;
    logic [0:0]      rspId;
    logic            lifoPush;
    logic            lifoPop;
    logic [BW-1:0]   lifoPushData;
    logic            lifoFull;
    logic            lifoEmpty;
    logic [BW-1:0]   lifoPopData;
`ifdef LIFO_ARB_STATS_EN
    logic [31:0]     statPush;
    logic [31:0]     statPop;
    logic [31:0]     statStall;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lifo_arb #(.bW(BW), .nR(NR)) dut (
        .clk          (clk),
        .rst          (rst),
        .reqValid     (reqValid),
        .reqOp        (reqOp),
        .reqLock      (reqLock),
        .reqData      (reqData),
        .reqReady     (reqReady),
        .rspValid     (rspValid),
        .rspData      (rspData),
        .rspId        (rspId),
        .lifoPush     (lifoPush),
        .lifoPop      (lifoPop),
        .lifoPushData (lifoPushData),
        .lifoFull     (lifoFull),
        .lifoEmpty    (lifoEmpty),
        .lifoPopData  (lifoPopData)
`ifdef LIFO_ARB_STATS_EN
        ,
        .statPush     (statPush),
        .statPop      (statPop),
        .statStall    (statStall)
`endif
    );

    // Behavioural LIFO with EC entries, cleared together with the arbiter.
    logic [BW-1:0] lmem [EC];
    int            lcnt = 0;

    always @(posedge clk) begin
        if (!rst) begin
            lcnt <= 0;
        end else if (lifoPush && lcnt < EC) begin
            lmem[lcnt] <= lifoPushData;
            lcnt       <= lcnt + 1;
        end else if (lifoPop && lcnt > 0) begin
            lcnt <= lcnt - 1;
        end
    end

    assign lifoFull    = (lcnt == EC);
    assign lifoEmpty   = (lcnt == 0);
    assign lifoPopData = (lcnt > 0) ? lmem[lcnt-1] : '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] op, input logic [1:0] lk,
                         input logic [7:0] d0, input logic [7:0] d1);
        reqValid = v;
        reqOp    = op;
        reqLock  = lk;
        reqData  = {d1, d0};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One reset edge with requests pending; grant outputs must stay quiet.
    task automatic do_reset();
        rst = 1'b0;
        drive(2'b11, 2'b00, 2'b11, 8'hEE, 8'hDD);
        #4;
        check("rst_ready", 32'(reqReady), 32'h0);
        check("rst_push", 32'(lifoPush), 32'h0);
        check("rst_pop", 32'(lifoPop), 32'h0);
        next_cycle();
        rst = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
        check("rst_rspValid", 32'(rspValid), 32'h0);
        check("rst_rspData", 32'(rspData), 32'h0);
        check("rst_rspId", 32'(rspId), 32'h0);
    endtask

    // Single cycle: apply inputs, check grant, push data and response valid.
    task automatic step(input string tag, input logic [1:0] v, input logic [1:0] op,
                        input logic [1:0] lk, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] e_rdy, input logic [7:0] e_pd, input logic e_rv);
        drive(v, op, lk, d0, d1);
        #4;
        check({tag, "_ready"}, 32'(reqReady), 32'(e_rdy));
        check({tag, "_pushData"}, 32'(lifoPushData), 32'(e_pd));
        check({tag, "_rspValid"}, 32'(rspValid), 32'(e_rv));
        next_cycle();
    endtask

    typedef struct {
        logic [1:0] v, op, lk;
        logic [7:0] d0, d1;
        logic [1:0] rdy;
        logic       psh, pp;
        logic [7:0] pd;
        logic       rv;
        logic [7:0] rd;
        logic       rid;
    } vec_t;

    function automatic vec_t mk(logic [1:0] v, logic [1:0] op, logic [7:0] d1,
                                logic [1:0] rdy, logic psh, logic pp, logic [7:0] pd,
                                logic rv, logic [7:0] rd, logic rid);
        vec_t r;
        r.v = v; r.op = op; r.lk = 2'b00; r.d0 = 8'h11; r.d1 = d1;
        r.rdy = rdy; r.psh = psh; r.pp = pp; r.pd = pd;
        r.rv = rv; r.rd = rd; r.rid = rid;
        return r;
    endfunction

    vec_t tbl [18];

    // Reference model state for the random phase.
    logic          pend [NR];
    logic          pop_op [NR];
    logic          lk_rq [NR];
    logic [7:0]    dat [NR];
    int            m_ptr, m_owner, e_rid, stuck, g, n_push, n_pop, n_stall;
    bit            m_locked, e_rv, any_pend;
    logic [7:0]    e_rd;
    logic [1:0]    v_vec, op_vec, lk_vec;

    initial begin
        // v, op, d1 | ready, push, pop, pushData | rspValid, rspData, rspId
        tbl[0]  = mk(2'b11, 2'b00, 8'h22, 2'b01, 1, 0, 8'h11, 0, 8'h00, 0);
        tbl[1]  = mk(2'b11, 2'b00, 8'h22, 2'b10, 1, 0, 8'h22, 0, 8'h00, 0);
        tbl[2]  = mk(2'b11, 2'b00, 8'h22, 2'b01, 1, 0, 8'h11, 0, 8'h00, 0);
        tbl[3]  = mk(2'b11, 2'b00, 8'h22, 2'b10, 1, 0, 8'h22, 0, 8'h00, 0);
        tbl[4]  = mk(2'b11, 2'b10, 8'h22, 2'b10, 0, 1, 8'h00, 0, 8'h00, 0);
        tbl[5]  = mk(2'b01, 2'b00, 8'h22, 2'b01, 1, 0, 8'h11, 1, 8'h22, 1);
        tbl[6]  = mk(2'b00, 2'b00, 8'h22, 2'b00, 0, 0, 8'h00, 0, 8'h22, 1);
        tbl[7]  = mk(2'b01, 2'b00, 8'h22, 2'b00, 0, 0, 8'h00, 0, 8'h22, 1);
        tbl[8]  = mk(2'b01, 2'b01, 8'h22, 2'b01, 0, 1, 8'h00, 0, 8'h22, 1);
        tbl[9]  = mk(2'b10, 2'b00, 8'hA5, 2'b10, 1, 0, 8'hA5, 1, 8'h11, 0);
        tbl[10] = mk(2'b10, 2'b10, 8'hA5, 2'b10, 0, 1, 8'h00, 0, 8'h11, 0);
        tbl[11] = mk(2'b00, 2'b00, 8'h22, 2'b00, 0, 0, 8'h00, 1, 8'hA5, 1);
        tbl[12] = mk(2'b00, 2'b00, 8'h22, 2'b00, 0, 0, 8'h00, 0, 8'hA5, 1);
        tbl[13] = mk(2'b01, 2'b01, 8'h22, 2'b01, 0, 1, 8'h00, 0, 8'hA5, 1);
        tbl[14] = mk(2'b11, 2'b11, 8'h22, 2'b10, 0, 1, 8'h00, 1, 8'h11, 0);
        tbl[15] = mk(2'b11, 2'b11, 8'h22, 2'b01, 0, 1, 8'h00, 1, 8'h22, 1);
        tbl[16] = mk(2'b11, 2'b11, 8'h22, 2'b00, 0, 0, 8'h00, 1, 8'h11, 0);
        tbl[17] = mk(2'b00, 2'b00, 8'h22, 2'b00, 0, 0, 8'h00, 0, 8'h11, 0);

        next_cycle();
        do_reset();

        // Round robin, full gating, pop response, drain to empty.
        for (int r = 0; r < 18; r++) begin
            drive(tbl[r].v, tbl[r].op, tbl[r].lk, tbl[r].d0, tbl[r].d1);
            #4;
            check($sformatf("row%0d_ready", r), 32'(reqReady), 32'(tbl[r].rdy));
            check($sformatf("row%0d_push", r), 32'(lifoPush), 32'(tbl[r].psh));
            check($sformatf("row%0d_pop", r), 32'(lifoPop), 32'(tbl[r].pp));
            check($sformatf("row%0d_pushData", r), 32'(lifoPushData), 32'(tbl[r].pd));
            check($sformatf("row%0d_rspValid", r), 32'(rspValid), 32'(tbl[r].rv));
            check($sformatf("row%0d_rspData", r), 32'(rspData), 32'(tbl[r].rd));
            check($sformatf("row%0d_rspId", r), 32'(rspId), 32'(tbl[r].rid));
            next_cycle();
        end

        // Lock burst: req0 holds the LIFO for three pushes, then req1 wins.
        do_reset();
        step("lk_a", 2'b11, 2'b00, 2'b01, 8'h31, 8'h42, 2'b01, 8'h31, 0);
        step("lk_b", 2'b11, 2'b00, 2'b01, 8'h32, 8'h42, 2'b01, 8'h32, 0);
        step("lk_c", 2'b11, 2'b00, 2'b00, 8'h33, 8'h42, 2'b01, 8'h33, 0);
        step("lk_d", 2'b11, 2'b00, 2'b00, 8'h34, 8'h42, 2'b10, 8'h42, 0);

        // Reset mid-lock: owner 1 goes quiet, lock holds, reset releases it.
        do_reset();
        step("rl_a", 2'b10, 2'b00, 2'b10, 8'h00, 8'h55, 2'b10, 8'h55, 0);
        step("rl_b", 2'b01, 2'b00, 2'b00, 8'h66, 8'h00, 2'b00, 8'h00, 0);
        step("rl_c", 2'b01, 2'b00, 2'b00, 8'h66, 8'h00, 2'b00, 8'h00, 0);
        do_reset();
        step("rl_d", 2'b11, 2'b00, 2'b00, 8'h77, 8'h88, 2'b01, 8'h77, 0);
        step("rl_e", 2'b11, 2'b00, 2'b00, 8'h77, 8'h88, 2'b10, 8'h88, 0);

        // Empty pop: five cycles of a pop against an empty LIFO.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            step("ep", 2'b01, 2'b01, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 0);
        end
        check("ep_rspValid_after", 32'(rspValid), 32'h0);
`ifdef LIFO_ARB_STATS_EN
        check("ep_statStall", statStall, 32'd5);
        check("ep_statPop", statPop, 32'd0);
`endif

        // Randomized traffic against the reference model.
        do_reset();
        m_ptr = 0; m_locked = 0; m_owner = 0; stuck = 0;
        e_rv = 0; e_rd = '0; e_rid = 0;
        n_push = 0; n_pop = 0; n_stall = 0;
        for (int i = 0; i < NR; i++) pend[i] = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            any_pend = 0;
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]   = 1;
                    pop_op[i] = 1'($urandom_range(0, 1));
                    lk_rq[i]  = ($urandom_range(0, 5) == 0);
                    dat[i]    = 8'($urandom);
                end
                v_vec[i]  = pend[i];
                op_vec[i] = pend[i] && pop_op[i];
                lk_vec[i] = pend[i] && lk_rq[i];
                any_pend  = any_pend || pend[i];
            end
            drive(v_vec, op_vec, lk_vec, pend[0] ? dat[0] : 8'h00, pend[1] ? dat[1] : 8'h00);
            #4;
            g = -1;
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_ptr + k) % NR;
                if (g < 0 && pend[i] && (!m_locked || i == m_owner) &&
                    (pop_op[i] ? (lcnt > 0) : (lcnt < EC))) begin
                    g = i;
                end
            end
            check("rnd_ready", 32'(reqReady), (g >= 0) ? (32'd1 << g) : 32'd0);
            check("rnd_push", 32'(lifoPush), 32'(g >= 0 && !pop_op[g]));
            check("rnd_pop", 32'(lifoPop), 32'(g >= 0 && pop_op[g]));
            check("rnd_pushData", 32'(lifoPushData), (g >= 0 && !pop_op[g]) ? 32'(dat[g]) : 32'd0);
            check("rnd_rspValid", 32'(rspValid), 32'(e_rv));
            check("rnd_rspData", 32'(rspData), 32'(e_rd));
            check("rnd_rspId", 32'(rspId), 32'(e_rid));
            if (g >= 0) begin
                pend[g] = 0;
                m_ptr   = (g + 1) % NR;
                if (!m_locked && lk_rq[g]) begin
                    m_locked = 1;
                    m_owner  = g;
                end else if (m_locked && !lk_rq[g]) begin
                    m_locked = 0;
                end
                if (pop_op[g]) begin
                    e_rv  = 1;
                    e_rd  = lmem[lcnt-1];
                    e_rid = g;
                    n_pop++;
                end else begin
                    e_rv = 0;
                    n_push++;
                end
            end else begin
                e_rv = 0;
                if (any_pend) n_stall++;
            end
            stuck = (m_locked && g < 0) ? stuck + 1 : 0;
            next_cycle();
            if (stuck >= 12) begin
                do_reset();
                m_ptr = 0; m_locked = 0; m_owner = 0; stuck = 0;
                e_rv = 0; e_rd = '0; e_rid = 0;
                n_push = 0; n_pop = 0; n_stall = 0;
                for (int i = 0; i < NR; i++) pend[i] = 0;
            end
        end
`ifdef LIFO_ARB_STATS_EN
        check("rnd_statPush", statPush, 32'(n_push));
        check("rnd_statPop", statPop, 32'(n_pop));
        check("rnd_statStall", statStall, 32'(n_stall));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
